// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and counter type for the 480x272 RGB LCD raster generator.
package lcd_timing_pkg;

    localparam int LCD_CLK_DIV  = 3;
    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FRONT  = 2;
    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BACK   = 2;
    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FRONT  = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BACK   = 2;

    localparam int LCD_H_TOTAL = LCD_H_ACTIVE + LCD_H_FRONT + LCD_H_SYNC + LCD_H_BACK;
    localparam int LCD_V_TOTAL = LCD_V_ACTIVE + LCD_V_FRONT + LCD_V_SYNC + LCD_V_BACK;

    typedef logic [9:0] lcd_cnt_t;

    // Half-open window test [lo, hi) used for the sync pulse regions.
    function automatic logic in_window(input lcd_cnt_t cnt, input lcd_cnt_t lo,
                                       input lcd_cnt_t hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/lcd_pixel_tick.sv
// Pixel-rate divider: one-clock pixel_tick every CLK_DIV clocks and the panel pixel clock.
module lcd_pixel_tick #(
    parameter int CLK_DIV = 3
) (
    input  logic clock,
    input  logic reset,
    output logic pixel_tick,
    output logic lcd_clk
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Gated by reset so both outputs read 0 while held; with CLK_DIV=1 both are simply high.
    assign pixel_tick = reset && (div_cnt == DIV_LAST);
    assign lcd_clk    = reset && ((CLK_DIV == 1) || (int'(div_cnt) < CLK_DIV / 2));

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing for the RGB LCD: h/v counters on pixel_tick and a registered output stage
// (one pixel of latency) producing hsync, vsync, de, x, y and frame_start.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int CLK_DIV  = LCD_CLK_DIV,
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FRONT  = LCD_H_FRONT,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BACK   = LCD_H_BACK,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FRONT  = LCD_V_FRONT,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BACK   = LCD_V_BACK
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       lcd_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam lcd_cnt_t H_LAST = lcd_cnt_t'(H_TOTAL - 1);
    localparam lcd_cnt_t V_LAST = lcd_cnt_t'(V_TOTAL - 1);
    localparam lcd_cnt_t H_ACT  = lcd_cnt_t'(H_ACTIVE);
    localparam lcd_cnt_t V_ACT  = lcd_cnt_t'(V_ACTIVE);
    localparam lcd_cnt_t HS_BEG = lcd_cnt_t'(H_ACTIVE + H_FRONT);
    localparam lcd_cnt_t HS_END = lcd_cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam lcd_cnt_t VS_BEG = lcd_cnt_t'(V_ACTIVE + V_FRONT);
    localparam lcd_cnt_t VS_END = lcd_cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);

    lcd_cnt_t h_cnt;
    lcd_cnt_t v_cnt;
    logic     de_p0;
    logic     hs_p0;
    logic     vs_p0;
    logic     sof_p0;

    lcd_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .clock     (clock),
        .reset     (reset),
        .pixel_tick(pixel_tick),
        .lcd_clk   (lcd_clk)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + lcd_cnt_t'(1);
            end else begin
                h_cnt <= h_cnt + lcd_cnt_t'(1);
            end
        end
    end

    // Stage p0: region decode of the current counter position
    always_comb begin
        de_p0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_p0  = in_window(h_cnt, HS_BEG, HS_END);
        vs_p0  = in_window(v_cnt, VS_BEG, VS_END);
        sof_p0 = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage p1: registered panel outputs, held between ticks except the frame_start pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (pixel_tick) begin
            hsync       <= ~hs_p0;
            vsync       <= ~vs_p0;
            de          <= de_p0;
            x           <= de_p0 ? h_cnt[8:0] : '0;
            y           <= de_p0 ? v_cnt[8:0] : '0;
            frame_start <= sof_p0;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: full 480x272 line timing plus reduced geometries for
// frame-level, wrap, mid-frame reset and CLK_DIV=1/4 behaviour.
module tb_lcd_timing_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [3:0]      rst_v = 4'b0000;
    logic [3:0]      tick_v, lcd_v, hs_v, vs_v, de_v, fs_v;
    logic [3:0][8:0] x_v, y_v;

    int checks = 0;
    int errors = 0;

    int tick_cnt, gap_err, lcd_hi, upd_cnt, de_cnt, seq_err, hs_low, vs_low;
    int fs_n, line_n, maxy;
    int fs_t[4];
    int line_t[4];

    // 0: full panel CLK_DIV=3; 1..3: 15x10 raster with CLK_DIV 3, 1, 4
    lcd_timing_gen u0 (
        .clock(clock), .reset(rst_v[0]), .pixel_tick(tick_v[0]), .lcd_clk(lcd_v[0]),
        .hsync(hs_v[0]), .vsync(vs_v[0]), .de(de_v[0]), .x(x_v[0]), .y(y_v[0]),
        .frame_start(fs_v[0]));

    lcd_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u1 (
        .clock(clock), .reset(rst_v[1]), .pixel_tick(tick_v[1]), .lcd_clk(lcd_v[1]),
        .hsync(hs_v[1]), .vsync(vs_v[1]), .de(de_v[1]), .x(x_v[1]), .y(y_v[1]),
        .frame_start(fs_v[1]));

    lcd_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u2 (
        .clock(clock), .reset(rst_v[2]), .pixel_tick(tick_v[2]), .lcd_clk(lcd_v[2]),
        .hsync(hs_v[2]), .vsync(vs_v[2]), .de(de_v[2]), .x(x_v[2]), .y(y_v[2]),
        .frame_start(fs_v[2]));

    lcd_timing_gen #(.CLK_DIV(4), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u3 (
        .clock(clock), .reset(rst_v[3]), .pixel_tick(tick_v[3]), .lcd_clk(lcd_v[3]),
        .hsync(hs_v[3]), .vsync(vs_v[3]), .de(de_v[3]), .x(x_v[3]), .y(y_v[3]),
        .frame_start(fs_v[3]));

    // Hold one instance in reset for n clocks, release between edges.
    task automatic pulse_reset(input int idx, input int n);
        @(negedge clock);
        rst_v[idx] = 1'b0;
        repeat (n) @(negedge clock);
        rst_v[idx] = 1'b1;
        #1;
    endtask

    // Free-run one instance for nclk edges, sampling on the falling edge, and gather stats.
    task automatic measure(input int idx, input int nclk, input int div, input int ha,
                           input int va);
        int  ex, ey, last_tick;
        bit  prev_tick, prev_de;
        tick_cnt = 0; gap_err = 0; lcd_hi = 0; upd_cnt = 0; de_cnt = 0; seq_err = 0;
        hs_low = 0; vs_low = 0; fs_n = 0; line_n = 0; maxy = -1;
        ex = 0; ey = 0; last_tick = -1; prev_de = 1'b0;
        prev_tick = tick_v[idx];
        for (int k = 1; k <= nclk; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (tick_v[idx]) begin
                tick_cnt++;
                if (last_tick >= 0 && k - last_tick != div) gap_err++;
                last_tick = k;
            end
            if (lcd_v[idx]) lcd_hi++;
            if (!vs_v[idx]) vs_low++;
            if (fs_v[idx]) begin
                if (fs_n < 4) fs_t[fs_n] = k;
                fs_n++;
            end
            if (prev_tick) begin
                upd_cnt++;
                if (!hs_v[idx]) hs_low++;
                if (de_v[idx]) begin
                    de_cnt++;
                    if (int'(x_v[idx]) != ex || int'(y_v[idx]) != ey) seq_err++;
                    if (!prev_de && line_n < 4) begin
                        line_t[line_n] = k;
                        line_n++;
                    end
                    if (int'(y_v[idx]) > maxy) maxy = int'(y_v[idx]);
                    ex++;
                    if (ex == ha) begin
                        ex = 0;
                        ey++;
                        if (ey == va) ey = 0;
                    end
                end else if (x_v[idx] != '0 || y_v[idx] != '0) begin
                    seq_err++;
                end
                prev_de = de_v[idx];
            end
            prev_tick = tick_v[idx];
        end
    endtask

    task automatic test_reset;
        int first_fs[4];
        int exp_fs[4];
        exp_fs = '{3, 3, 1, 4};
        rst_v = 4'b0000;
        repeat (5) @(negedge clock);
        #1;
        checks++;
        if (hs_v !== 4'hF || vs_v !== 4'hF) begin
            errors++;
            $display("FAIL reset_sync hsync=%b vsync=%b required 1111/1111", hs_v, vs_v);
        end
        checks++;
        if (de_v !== 4'h0 || fs_v !== 4'h0 || lcd_v !== 4'h0 || tick_v !== 4'h0) begin
            errors++;
            $display("FAIL reset_ctl de=%b fs=%b lcd=%b tick=%b required all 0000",
                     de_v, fs_v, lcd_v, tick_v);
        end
        checks++;
        if (x_v !== '0 || y_v !== '0) begin
            errors++;
            $display("FAIL reset_xy x=%h y=%h required 0", x_v, y_v);
        end
        @(negedge clock);
        rst_v = 4'b1111;
        first_fs = '{0, 0, 0, 0};
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            @(negedge clock);
            for (int i = 0; i < 4; i++)
                if (fs_v[i] && first_fs[i] == 0) first_fs[i] = k;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (first_fs[i] != exp_fs[i]) begin
                errors++;
                $display("FAIL first_frame_start[%0d] clock=%0d required %0d",
                         i, first_fs[i], exp_fs[i]);
            end
        end
    endtask

    task automatic test_lines;
        pulse_reset(0, 2);
        measure(0, 3150, 3, 480, 272);
        checks++;
        if (tick_cnt != 1050 || gap_err != 0) begin
            errors++;
            $display("FAIL line_tick ticks=%0d gap_err=%0d required 1050/0", tick_cnt, gap_err);
        end
        checks++;
        if (lcd_hi != 1050) begin
            errors++;
            $display("FAIL line_lcd_clk high=%0d required 1050", lcd_hi);
        end
        checks++;
        if (de_cnt != 960 || seq_err != 0) begin
            errors++;
            $display("FAIL line_de de=%0d seq_err=%0d required 960/0", de_cnt, seq_err);
        end
        checks++;
        if (hs_low != 82) begin
            errors++;
            $display("FAIL line_hsync low=%0d required 82", hs_low);
        end
        checks++;
        if (line_n < 2 || line_t[0] != 3 || line_t[1] - line_t[0] != 1575) begin
            errors++;
            $display("FAIL line_period starts=%0d first=%0d period=%0d required 3/1575",
                     line_n, line_t[0], line_t[1] - line_t[0]);
        end
        checks++;
        if (vs_low != 0 || maxy != 1) begin
            errors++;
            $display("FAIL line_v vs_low=%0d maxy=%0d required 0/1", vs_low, maxy);
        end
    endtask

    task automatic test_frames;
        pulse_reset(1, 2);
        measure(1, 905, 3, 8, 6);
        checks++;
        if (fs_n != 3 || fs_t[1] - fs_t[0] != 450 || fs_t[2] - fs_t[1] != 450) begin
            errors++;
            $display("FAIL frame_period pulses=%0d t=%0d,%0d,%0d required 3 at 450 spacing",
                     fs_n, fs_t[0], fs_t[1], fs_t[2]);
        end
        checks++;
        if (fs_t[2] != 903) begin
            errors++;
            $display("FAIL wrap_frame_start clock=%0d required 903", fs_t[2]);
        end
        checks++;
        if (de_cnt != 97 || seq_err != 0) begin
            errors++;
            $display("FAIL frame_de de=%0d seq_err=%0d required 97/0", de_cnt, seq_err);
        end
        checks++;
        if (vs_low != 180) begin
            errors++;
            $display("FAIL frame_vsync low_clocks=%0d required 180", vs_low);
        end
        checks++;
        if (hs_low != 60 || maxy != 5) begin
            errors++;
            $display("FAIL frame_hsync_y hs_low=%0d maxy=%0d required 60/5", hs_low, maxy);
        end
    endtask

    task automatic test_mid_reset;
        bit found = 1'b0;
        pulse_reset(1, 2);
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clock);
            if (de_v[1] && x_v[1] == 9'd5 && y_v[1] == 9'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_reach found=%0d required 1", found);
        end
        #1 rst_v[1] = 1'b0;
        #1;
        checks++;
        if (de_v[1] !== 1'b0 || x_v[1] !== '0 || y_v[1] !== '0 || hs_v[1] !== 1'b1 ||
            vs_v[1] !== 1'b1 || fs_v[1] !== 1'b0 || lcd_v[1] !== 1'b0 || tick_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async de=%b x=%0d y=%0d hs=%b vs=%b fs=%b lcd=%b tick=%b required reset values",
                     de_v[1], x_v[1], y_v[1], hs_v[1], vs_v[1], fs_v[1], lcd_v[1], tick_v[1]);
        end
        repeat (2) @(negedge clock);
        rst_v[1] = 1'b1;
        #1;
        measure(1, 10, 3, 8, 6);
        checks++;
        if (line_n < 1 || line_t[0] != 3 || fs_n != 1 || fs_t[0] != 3 || seq_err != 0) begin
            errors++;
            $display("FAIL mid_reset_restart de_start=%0d fs=%0d@%0d seq_err=%0d required 3, 1@3, 0",
                     line_t[0], fs_n, fs_t[0], seq_err);
        end
    endtask

    task automatic test_clk_div;
        pulse_reset(2, 2);
        measure(2, 305, 1, 8, 6);
        checks++;
        if (tick_cnt != 305 || lcd_hi != 305) begin
            errors++;
            $display("FAIL div1_tick ticks=%0d lcd_high=%0d required 305/305", tick_cnt, lcd_hi);
        end
        checks++;
        if (fs_n != 3 || fs_t[0] != 1 || fs_t[1] - fs_t[0] != 150 || fs_t[2] - fs_t[1] != 150 ||
            seq_err != 0) begin
            errors++;
            $display("FAIL div1_frame pulses=%0d t=%0d,%0d,%0d seq_err=%0d required 3 at 1,151,301",
                     fs_n, fs_t[0], fs_t[1], fs_t[2], seq_err);
        end
        pulse_reset(3, 2);
        measure(3, 1208, 4, 8, 6);
        checks++;
        if (tick_cnt != 302 || gap_err != 0 || lcd_hi != 604) begin
            errors++;
            $display("FAIL div4_tick ticks=%0d gap_err=%0d lcd_high=%0d required 302/0/604",
                     tick_cnt, gap_err, lcd_hi);
        end
        checks++;
        if (fs_n != 3 || fs_t[0] != 4 || fs_t[1] - fs_t[0] != 600 || fs_t[2] - fs_t[1] != 600 ||
            seq_err != 0) begin
            errors++;
            $display("FAIL div4_frame pulses=%0d t=%0d,%0d,%0d seq_err=%0d required 3 at 4,604,1204",
                     fs_n, fs_t[0], fs_t[1], fs_t[2], seq_err);
        end
    endtask

    initial begin
        test_reset();
        test_lines();
        test_frames();
        test_mid_reset();
        test_clk_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
